snn_synapse_sequencer: RTL and testbench
========================================

# snn_synapse_sequencer

Time-multiplexed synapse scheduler for the robot SNN. It replaces the per-pair synapse instances with a single sequenced multiply-free accumulate path. Per timestep it takes a snapshot of the input-neuron spike vector and walks a writable INPUTNUM×EXCNUM weight table, one synapse per cycle. It then emits one saturated summed drive per excitatory neuron, with a one-cycle valid pulse. It sits between the input neurons and the excitatory neurons.

## Interface
- INPUTNUM, 4, number of input (sensor) neurons
- EXCNUM, 2, number of excitatory (output) neurons
- WW, 24, signed weight width
- SHIFT, 16, arithmetic right shift applied to each weight before accumulation
- SUM_DW, 16, signed width of each output sum
- AW, $clog2(INPUTNUM*EXCNUM), weight address width
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; when low, all state holds
- start  in  1  timestep strobe, one cycle
- pre_spike  in  INPUTNUM  spike vector; bit i = input neuron i
- wr_en  in  1  weight write strobe
- wr_addr  in  AW  weight index = i*EXCNUM + j
- wr_data  in  WW  signed weight
- wr_ready  out  1  high when a write is accepted (= state IDLE)
- after_sum  out  EXCNUM*SUM_DW  packed sums; neuron j at [SUM_DW*(j+1)-1 : SUM_DW*j]
- sum_valid  out  1  one-cycle pulse, after_sum just updated
- busy  out  1  high in ACCUM and DONE
- overrun  out  1  sticky; start arrived while not IDLE

## Operation
- Weight RAM: INPUTNUM*EXCNUM entries of WW bits, registers, all 0 after rst.
  - A write occurs on a clk edge when wr_en && wr_ready && en.
  - wr_addr ≥ INPUTNUM*EXCNUM: ignored.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: on en && start, latch pre_spike into snap, clear EXCNUM accumulators (32-bit signed), set i=0, j=0, go to ACCUM.
  - ACCUM: each enabled cycle, if snap[i] then acc[j] += sign_extend(w[i*EXCNUM+j] >>> SHIFT). Index j runs as the inner loop and i as the outer. After i=INPUTNUM-1, j=EXCNUM-1, go to DONE.
  - DONE: after_sum[j] <= sat(acc[j]), sum_valid <= 1, go to IDLE.
- Shift rounding: arithmetic shift, floor rounding (-88929 >>> 16 = -2).
- Saturation: clamp to [-2^(SUM_DW-1), 2^(SUM_DW-1)-1], applied once, at DONE.
- start while not IDLE (en high): ignored; overrun <= 1; overrun clears only on rst.
- wr_en while busy: dropped, with no side effect. The writer must check wr_ready.
- pre_spike changes after the start cycle: no effect on the current timestep.
- en low: FSM, indices, accumulators, weights and outputs hold; sum_valid forced 0 that cycle. The pulse is re-issued when en returns, because DONE is still pending.
- rst (any state): IDLE, accumulators 0, weights 0, after_sum 0, sum_valid 0, busy 0, overrun 0.

## Timing
- Label as E0 the edge where start is sampled in IDLE. Accumulation occurs at edges E1 through E(INPUTNUM*EXCNUM). DONE commits at E(INPUTNUM*EXCNUM+1).
- With defaults, sums are committed at E9. sum_valid is high for the single cycle after E9, and after_sum is stable from then on.
- busy goes high after E0 and low after E9. wr_ready = !busy.
- Earliest next accepted start: E10. The minimum start period is INPUTNUM*EXCNUM+2 cycles.
- Each cycle with en low adds exactly one cycle of latency.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst for 2 cycles mid-ACCUM. Required: after_sum=0, sum_valid=0, busy=0, overrun=0, wr_ready=1. After rst, spikes=4'b1111 with no writes gives sums 0/0.
- Nominal: write w0..w7 = 1615585, 592018, 2564138, -153494, -88929, 3681132, 568763, 2266863. Apply spikes=4'b1111, start. Required: sum_valid 9 cycles after start, sum0=69, sum1=96.
- Partial spikes: same weights, spikes=4'b0101. Required: sum0=22, sum1=65. Changing pre_spike at E1 has no effect.
- Saturation (SHIFT=0 instance): all weights 8388607 with spikes=4'b1111 gives 32767/32767. All weights -8388608 gives -32768/-32768.
- Overrun and writes while busy: pulse start at E3, and write w0=0 at E4. Required: overrun=1 and stays set, wr_ready=0 during E1–E9, w0 unchanged, results as in the nominal case, and exactly one sum_valid.
- Enable stall: drop en for 3 cycles at E4. Required: sum_valid at E12, same sums, no writes taken while en is low.

Source files
------------

// File: rtl/snn_synapse_sequencer_if.sv
// Handshake/bus bundle for snn_synapse_sequencer: timestep strobe, spike vector,
// weight-write port and the summed-drive outputs.
interface snn_synapse_sequencer_if #(
  parameter int INPUTNUM = 4,
  parameter int EXCNUM   = 2,
  parameter int WW       = 24,
  parameter int SUM_DW   = 16,
  parameter int AW       = $clog2(INPUTNUM*EXCNUM)
);
  logic                     start;
  logic [INPUTNUM-1:0]      pre_spike;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [WW-1:0]            wr_data;
  logic                     wr_ready;
  logic [EXCNUM*SUM_DW-1:0] after_sum;
  logic                     sum_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output start, pre_spike, wr_en, wr_addr, wr_data,
    input  wr_ready, after_sum, sum_valid, busy, overrun
  );

  modport slave (
    input  start, pre_spike, wr_en, wr_addr, wr_data,
    output wr_ready, after_sum, sum_valid, busy, overrun
  );
endinterface

// File: rtl/snn_synapse_sequencer.sv
// Time-multiplexed synapse scheduler: walks the INPUTNUM x EXCNUM weight table one
// synapse per cycle and emits one saturated summed drive per excitatory neuron.
module snn_synapse_sequencer #(
  parameter int INPUTNUM = 4,
  parameter int EXCNUM   = 2,
  parameter int WW       = 24,
  parameter int SHIFT    = 16,
  parameter int SUM_DW   = 16,
  parameter int AW       = $clog2(INPUTNUM*EXCNUM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  snn_synapse_sequencer_if.slave  bus
);
  localparam int unsigned NSYN = INPUTNUM * EXCNUM;
  localparam int ACCW = 32;
  localparam int IW   = (INPUTNUM > 1) ? $clog2(INPUTNUM) : 1;
  localparam int JW   = (EXCNUM > 1) ? $clog2(EXCNUM) : 1;
  localparam longint SMAX = (longint'(1) << (SUM_DW - 1)) - 1;
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(SMAX);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-SMAX - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                   state;
  logic [INPUTNUM-1:0]      snap;
  logic [IW-1:0]            i;
  logic [JW-1:0]            j;
  logic [AW-1:0]            addr;
  logic signed [WW-1:0]     w   [NSYN];
  logic signed [ACCW-1:0]   acc [EXCNUM];
  logic signed [WW-1:0]     w_shift;
  logic signed [ACCW-1:0]   term;
  logic [EXCNUM*SUM_DW-1:0] after_sum_r;
  logic                     sum_valid_r;
  logic                     busy_r;
  logic                     wr_ready_r;
  logic                     overrun_r;

  function automatic logic [SUM_DW-1:0] sat(input logic signed [ACCW-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[SUM_DW-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[SUM_DW-1:0];
    else                  sat = v[SUM_DW-1:0];
  endfunction

  // Floor-rounded shift, then explicit sign extension into the accumulator width.
  always_comb begin
    w_shift = w[addr] >>> SHIFT;
    term    = {{(ACCW-WW){w_shift[WW-1]}}, w_shift};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      snap        <= '0;
      i           <= '0;
      j           <= '0;
      addr        <= '0;
      after_sum_r <= '0;
      sum_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      wr_ready_r  <= 1'b1;
      overrun_r   <= 1'b0;
      for (int unsigned k = 0; k < NSYN; k++) w[k] <= '0;
      for (int unsigned k = 0; k < EXCNUM; k++) acc[k] <= '0;
    end else begin
      sum_valid_r <= 1'b0;
      if (en) begin
        if (bus.start && state != IDLE) overrun_r <= 1'b1;
        if (bus.wr_en && wr_ready_r && 32'(bus.wr_addr) < NSYN)
          w[bus.wr_addr] <= bus.wr_data;
        case (state)
          IDLE: begin
            if (bus.start) begin
              snap       <= bus.pre_spike;
              i          <= '0;
              j          <= '0;
              addr       <= '0;
              busy_r     <= 1'b1;
              wr_ready_r <= 1'b0;
              state      <= ACCUM;
              for (int unsigned k = 0; k < EXCNUM; k++) acc[k] <= '0;
            end
          end
          ACCUM: begin
            if (snap[i]) acc[j] <= acc[j] + term;
            addr <= addr + 1'b1;
            if (j == JW'(EXCNUM - 1)) begin
              j <= '0;
              if (i == IW'(INPUTNUM - 1)) state <= DONE;
              else                        i     <= i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end
          DONE: begin
            for (int unsigned k = 0; k < EXCNUM; k++)
              after_sum_r[k*SUM_DW +: SUM_DW] <= sat(acc[k]);
            sum_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            wr_ready_r  <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.after_sum = after_sum_r;
  assign bus.sum_valid = sum_valid_r;
  assign bus.busy      = busy_r;
  assign bus.wr_ready  = wr_ready_r;
  assign bus.overrun   = overrun_r;
endmodule

// File: tb/tb_snn_synapse_sequencer.sv
// Scoreboard bench for snn_synapse_sequencer: a SHIFT=16 instance for the nominal
// cases and a SHIFT=0 instance for saturation.
module tb_snn_synapse_sequencer;
  localparam int AW = 3;
  localparam int WW = 24;

  typedef struct {
    longint s0;
    longint s1;
    longint cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst;
  logic   en;
  longint cyc = 0;
  int     checks = 0;
  int     failures = 0;
  exp_t   qa[$];
  exp_t   qb[$];
  exp_t   ea;
  exp_t   eb;
  longint wts[8] = '{1615585, 592018, 2564138, -153494, -88929, 3681132, 568763, 2266863};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snn_synapse_sequencer_if #(.INPUTNUM(4), .EXCNUM(2), .WW(24), .SUM_DW(16), .AW(3)) bus_a ();
  snn_synapse_sequencer_if #(.INPUTNUM(4), .EXCNUM(2), .WW(24), .SUM_DW(16), .AW(3)) bus_b ();

  snn_synapse_sequencer #(.INPUTNUM(4), .EXCNUM(2), .WW(24), .SHIFT(16), .SUM_DW(16), .AW(3))
    dut_a (.clk(clk), .rst(rst), .en(en), .bus(bus_a));
  snn_synapse_sequencer #(.INPUTNUM(4), .EXCNUM(2), .WW(24), .SHIFT(0), .SUM_DW(16), .AW(3))
    dut_b (.clk(clk), .rst(rst), .en(en), .bus(bus_b));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus_a.sum_valid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", 1, 0);
      end else begin
        ea = qa.pop_front();
        chk("a_sum0", $signed(bus_a.after_sum[15:0]), ea.s0);
        chk("a_sum1", $signed(bus_a.after_sum[31:16]), ea.s1);
        chk("a_valid_cycle", cyc, ea.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus_b.sum_valid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", 1, 0);
      end else begin
        eb = qb.pop_front();
        chk("b_sum0", $signed(bus_b.after_sum[15:0]), eb.s0);
        chk("b_sum1", $signed(bus_b.after_sum[31:16]), eb.s1);
        chk("b_valid_cycle", cyc, eb.cyc);
      end
    end
  end

  task automatic wr_a(input int idx, input longint data);
    @(negedge clk);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = AW'(idx);
    bus_a.wr_data = WW'(data);
    @(negedge clk);
    bus_a.wr_en   = 1'b0;
  endtask

  task automatic wr_b(input int idx, input longint data);
    @(negedge clk);
    bus_b.wr_en   = 1'b1;
    bus_b.wr_addr = AW'(idx);
    bus_b.wr_data = WW'(data);
    @(negedge clk);
    bus_b.wr_en   = 1'b0;
  endtask

  // Returns at the negedge after E0; lat is the edge count from E0 to the visible pulse.
  task automatic start_a(input logic [3:0] sp, input longint s0, input longint s1, input int lat);
    @(negedge clk);
    bus_a.start     = 1'b1;
    bus_a.pre_spike = sp;
    qa.push_back('{s0, s1, cyc + lat});
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  task automatic start_b(input logic [3:0] sp, input longint s0, input longint s1);
    @(negedge clk);
    bus_b.start     = 1'b1;
    bus_b.pre_spike = sp;
    qb.push_back('{s0, s1, cyc + 10});
    @(negedge clk);
    bus_b.start = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (bus_a.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("a_done_timeout", bus_a.busy, 0);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while (bus_b.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b_done_timeout", bus_b.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    bus_a.start = 1'b0; bus_a.pre_spike = '0; bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_b.start = 1'b0; bus_b.pre_spike = '0; bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_after_sum", bus_a.after_sum, 0);
    chk("rst_sum_valid", bus_a.sum_valid, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_overrun", bus_a.overrun, 0);
    chk("rst_wr_ready", bus_a.wr_ready, 1);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) wr_a(k, wts[k]);

    // Nominal
    start_a(4'b1111, 69, 96, 10);
    wait_idle_a();

    // Partial spikes; spike vector changed in time for E1 must be ignored
    start_a(4'b0101, 22, 65, 10);
    bus_a.pre_spike = 4'b1111;
    wait_idle_a();

    // Overrun start at E3, write attempt at E4
    start_a(4'b1111, 69, 96, 10);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("busy_wr_ready", bus_a.wr_ready, 0);
      if (k >= 3) chk("overrun_set", bus_a.overrun, 1);
      if (k == 2) bus_a.start = 1'b1;
      if (k == 3) begin
        bus_a.start   = 1'b0;
        bus_a.wr_en   = 1'b1;
        bus_a.wr_addr = '0;
        bus_a.wr_data = '0;
      end
      if (k == 4) bus_a.wr_en = 1'b0;
    end
    wait_idle_a();
    chk("idle_wr_ready", bus_a.wr_ready, 1);
    start_a(4'b0101, 22, 65, 10);
    wait_idle_a();
    chk("overrun_sticky", bus_a.overrun, 1);

    // Enable stall of 3 cycles at E4, with a write attempt while en is low
    start_a(4'b1111, 69, 96, 13);
    repeat (3) @(negedge clk);
    en = 1'b0;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    bus_a.wr_en = 1'b0;
    wait_idle_a();

    // Write while idle but en low must be dropped
    @(negedge clk);
    en = 1'b0;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    @(negedge clk);
    en = 1'b1;
    bus_a.wr_en = 1'b0;
    start_a(4'b1111, 69, 96, 10);
    wait_idle_a();

    // Reset mid-ACCUM clears outputs, sticky flag and weights
    @(negedge clk);
    bus_a.start = 1'b1; bus_a.pre_spike = 4'b1111;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_after_sum", bus_a.after_sum, 0);
    chk("midrst_sum_valid", bus_a.sum_valid, 0);
    chk("midrst_busy", bus_a.busy, 0);
    chk("midrst_overrun", bus_a.overrun, 0);
    chk("midrst_wr_ready", bus_a.wr_ready, 1);
    rst = 1'b0;
    start_a(4'b1111, 0, 0, 10);
    wait_idle_a();

    // Saturation on the SHIFT=0 instance
    for (int k = 0; k < 8; k++) wr_b(k, 8388607);
    start_b(4'b1111, 32767, 32767);
    wait_idle_b();
    for (int k = 0; k < 8; k++) wr_b(k, -8388608);
    start_b(4'b1111, -32768, -32768);
    wait_idle_b();

    repeat (3) @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
